camera_frame_writer: RTL and testbench

- Writer side of the frame buffer that feeds the image processor and VGA path.
- Samples OV7670 RGB565 byte stream (DATA_IN/HREF/VSYNC, clocked by camera PCLK), packs each byte pair into one RGB332 pixel, and produces write enable, linear address and pixel data for the 176x144 dual-port M9K buffer.
- The image processor and VGA driver read the same buffer on the other port.

---
 rtl/camera_frame_writer.sv | 148 ++++++++++++++
 tb/tb_camera_frame_writer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/camera_frame_writer.sv
// Camera frame writer: packs the OV7670 RGB565 byte stream into RGB332 pixels
// and issues writes into the 176x144 frame buffer, with frame-done pulses and
// a completed-frame counter. All logic is on the camera PCLK.
module camera_frame_writer #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_WIDTH    = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  VSYNC,
  input  logic                  HREF,
  input  logic [7:0]            DATA_IN,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
  output logic [7:0]            PIXEL_OUT,
  output logic                  FRAME_DONE,
  output logic [7:0]            FRAME_CNT
);

  // X and Y must be able to hold their saturation values (width / height).
  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0] X_LIM = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0] Y_LIM = YW'(SCREEN_HEIGHT);

  // VBLANK/IDLE_LINE record what the previous sample saw; FIRST/SECOND are
  // the byte phase inside an active line.
  typedef enum logic [1:0] {
    ST_VBLANK,
    ST_IDLE_LINE,
    ST_FIRST,
    ST_SECOND
  } state_e;

  state_e                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [2:0]            r_q, r_d;
  logic [2:0]            g_q, g_d;
  logic                  line_seen_q, line_seen_d;
  logic                  prev_href_q, prev_href_d;
  logic                  prev_vsync_q, prev_vsync_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            pix_q, pix_d;
  logic                  done_q, done_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] lin_addr;

  assign lin_addr = ADDR_WIDTH'(x_q)
                  + ADDR_WIDTH'(y_q) * ADDR_WIDTH'(SCREEN_WIDTH);

  assign W_EN          = w_en_q;
  assign WRITE_ADDRESS = addr_q;
  assign PIXEL_OUT     = pix_q;
  assign FRAME_DONE    = done_q;
  assign FRAME_CNT     = cnt_q;

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_FIRST;
      x_q          <= '0;
      y_q          <= '0;
      r_q          <= '0;
      g_q          <= '0;
      line_seen_q  <= 1'b0;
      prev_href_q  <= 1'b0;
      prev_vsync_q <= 1'b0;
      w_en_q       <= 1'b0;
      addr_q       <= '0;
      pix_q        <= '0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      r_q          <= r_d;
      g_q          <= g_d;
      line_seen_q  <= line_seen_d;
      prev_href_q  <= prev_href_d;
      prev_vsync_q <= prev_vsync_d;
      w_en_q       <= w_en_d;
      addr_q       <= addr_d;
      pix_q        <= pix_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state: VSYNC overrides everything, then active-line byte packing,
  // then end-of-line bookkeeping on the HREF falling edge.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    r_d          = r_q;
    g_d          = g_q;
    line_seen_d  = line_seen_q;
    prev_href_d  = HREF;
    prev_vsync_d = VSYNC;
    w_en_d       = 1'b0;
    addr_d       = addr_q;
    pix_d        = pix_q;
    done_d       = 1'b0;
    cnt_d        = cnt_q;

    if (VSYNC) begin
      state_d = ST_VBLANK;
      x_d     = '0;
      y_d     = '0;
      if (!prev_vsync_q && line_seen_q) begin
        done_d      = 1'b1;
        cnt_d       = cnt_q + 8'd1;
        line_seen_d = 1'b0;
      end
    end else if (HREF) begin
      if (state_q == ST_SECOND) begin
        state_d = ST_FIRST;
        if (x_q < X_LIM && y_q < Y_LIM) begin
          w_en_d = 1'b1;
          addr_d = lin_addr;
          pix_d  = {r_q, g_q, DATA_IN[4:3]};
        end
        if (x_q < X_LIM) begin
          x_d = x_q + XW'(1);
        end
      end else begin
        // Any non-SECOND state (including right after blanking) starts a pixel.
        state_d = ST_SECOND;
        r_d     = DATA_IN[7:5];
        g_d     = DATA_IN[2:0];
      end
    end else begin
      state_d = ST_IDLE_LINE;
      if (prev_href_q) begin
        x_d = '0;
        if (y_q < Y_LIM) begin
          y_d         = y_q + YW'(1);
          line_seen_d = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Self-checking bench for camera_frame_writer: random byte streams against a
// line/pixel-level reference model holding the expected write sequence.
module tb_camera_frame_writer;

  localparam int W = 176;
  localparam int H = 144;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        VSYNC = 1'b0;
  logic        HREF = 1'b0;
  logic [7:0]  DATA_IN = '0;
  logic        W_EN;
  logic [14:0] WRITE_ADDRESS;
  logic [7:0]  PIXEL_OUT;
  logic        FRAME_DONE;
  logic [7:0]  FRAME_CNT;

  camera_frame_writer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_WIDTH(15)) dut (
    .CLK(CLK), .RESET(RESET), .VSYNC(VSYNC), .HREF(HREF), .DATA_IN(DATA_IN),
    .W_EN(W_EN), .WRITE_ADDRESS(WRITE_ADDRESS), .PIXEL_OUT(PIXEL_OUT),
    .FRAME_DONE(FRAME_DONE), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct {int addr; int pix;} wr_t;
  wr_t q[$];
  int  y_m = 0;
  int  idx_m = 0;
  int  b0_m = 0;
  bit  seen_m = 0;
  int  exp_frames = 0;
  int  fbase = 0;
  int  done_cnt = 0;
  int  last_addr = -1;

  // Monitor: every write must match the head of the expected queue.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (W_EN) begin
        if (q.size() == 0) begin
          chk("unexpected_write", int'(WRITE_ADDRESS), -1);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_addr", int'(WRITE_ADDRESS), e.addr);
          chk("wr_pix", int'(PIXEL_OUT), e.pix);
        end
        last_addr = int'(WRITE_ADDRESS);
      end
      if (FRAME_DONE) done_cnt++;
    end
  end

  task automatic drive_byte(input int b);
    if (idx_m % 2 == 1) begin
      int px;
      px = (b0_m / 32) * 32 + (b0_m % 8) * 4 + (b / 8) % 4;
      if (y_m < H && idx_m / 2 < W) q.push_back('{y_m * W + idx_m / 2, px});
    end else begin
      b0_m = b;
    end
    idx_m++;
    @(negedge CLK);
    HREF = 1'b1;
    DATA_IN = 8'(b);
  endtask

  task automatic end_line();
    @(negedge CLK);
    HREF = 1'b0;
    DATA_IN = 8'($urandom_range(0, 255));
    idx_m = 0;
    if (y_m < H) begin
      y_m++;
      seen_m = 1'b1;
    end
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) drive_byte($urandom_range(0, 255));
    end_line();
    repeat ($urandom_range(1, 3)) @(negedge CLK);
  endtask

  task automatic vsync_pulse(input bit keep_href);
    @(negedge CLK);
    VSYNC = 1'b1;
    if (!keep_href) HREF = 1'b0;
    idx_m = 0;
    y_m = 0;
    if (seen_m) begin
      exp_frames++;
      seen_m = 1'b0;
    end
    repeat (3) @(negedge CLK);
    HREF = 1'b0;
    repeat (2) @(negedge CLK);
    VSYNC = 1'b0;
    #1;
    chk("frame_done_cnt", done_cnt, exp_frames);
    chk("frame_cnt", int'(FRAME_CNT), (exp_frames - fbase) % 256);
    chk("queue_drained", q.size(), 0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_wen", int'(W_EN), 0);
    chk("rst_addr", int'(WRITE_ADDRESS), 0);
    chk("rst_pix", int'(PIXEL_OUT), 0);
    chk("rst_done", int'(FRAME_DONE), 0);
    chk("rst_cnt", int'(FRAME_CNT), 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Directed latency: E5,18 at line 0 -> F7 at address 0 one cycle later
    drive_byte(8'hE5);
    drive_byte(8'h18);
    @(posedge CLK); #1;
    chk("lat_wen", int'(W_EN), 1);
    chk("lat_addr", int'(WRITE_ADDRESS), 0);
    chk("lat_pix", int'(PIXEL_OUT), 8'hF7);
    end_line();
    @(posedge CLK); #1;
    chk("lat_wen_low", int'(W_EN), 0);
    repeat (2) @(negedge CLK);
    vsync_pulse(1'b0);

    // Full frame: 144 lines of 352 bytes
    for (int l = 0; l < H; l++) send_line(352);
    vsync_pulse(1'b0);
    chk("full_last_addr", last_addr, 25343);

    // Overlong line then a 3-byte line
    send_line(360);
    send_line(3);
    vsync_pulse(1'b0);
    chk("short_last_addr", last_addr, 176);

    // 150 lines: short lines to 142, full-width from 143 onward
    for (int l = 0; l < 150; l++) send_line((l < 143) ? 2 : 352);
    vsync_pulse(1'b0);
    chk("sat_last_addr", last_addr, 25343);

    // VSYNC rising halfway through line 5 with HREF still high
    for (int l = 0; l < 5; l++) send_line(352);
    for (int i = 0; i < 101; i++) drive_byte($urandom_range(0, 255));
    vsync_pulse(1'b1);
    send_line(4);
    vsync_pulse(1'b0);
    chk("restart_last_addr", last_addr, 1);

    // Random frames
    for (int f = 0; f < 3; f++) begin
      int nl;
      nl = $urandom_range(1, 6);
      for (int l = 0; l < nl; l++) send_line($urandom_range(1, 400));
      vsync_pulse(1'(($urandom_range(0, 1))));
    end

    // Asynchronous reset mid-line after first byte E5
    drive_byte(8'hE5);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    HREF = 1'b0;
    #1;
    chk("arst_wen", int'(W_EN), 0);
    chk("arst_addr", int'(WRITE_ADDRESS), 0);
    chk("arst_pix", int'(PIXEL_OUT), 0);
    chk("arst_done", int'(FRAME_DONE), 0);
    chk("arst_cnt", int'(FRAME_CNT), 0);
    idx_m = 0;
    y_m = 0;
    seen_m = 1'b0;
    fbase = exp_frames;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    chk("post_rst_wen", int'(W_EN), 0);
    drive_byte(8'hE5);
    drive_byte(8'h18);
    end_line();
    @(negedge CLK);
    chk("post_rst_addr", last_addr, 0);
    vsync_pulse(1'b0);

    // 255 more short frames -> counter wraps back to 0
    for (int f = 0; f < 255; f++) begin
      send_line(2);
      vsync_pulse(1'b0);
    end
    chk("wrap_cnt", int'(FRAME_CNT), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
